// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i front end.
// The fetch FIFO carries fetch_entry_t records (PC plus instruction word).
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;  // ADDI x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Drop the byte offset so the PC can only ever hold word-aligned values.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// The head is presented combinationally and reads as all-zero while empty.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity and empty gates the head.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, reads the combinational instruction
// memory and queues {pc, inst} for decode; redirects flush the queue and reload the PC.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned IM_WORDS = 64,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_inst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            push, pop, pc_fault;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    wr_entry, head;

  assign pc_fault = ({2'b00, pc_q[XLEN-1:2]} >= 32'(IM_WORDS));

  // A pending redirect hides the head so decode never takes a stale entry.
  assign out_valid = ~fifo_empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign push      = ~halt & ~redirect_valid & (~fifo_full | pop);

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = pc_fault ? NOP_INST : im_inst;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d    = align_word(redirect_pc);
      fault_d = 1'b0;
    end else if (push) begin
      pc_d = next_pc(pc_q);
      if (pc_fault) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign im_addr     = pc_q;
  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected deliveries are queued by the stimulus
// and compared by an independent monitor on every accepted head.
module tb_fetch_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr, im_inst;
  logic        halt, redirect_valid, out_valid, out_ready, fetch_fault;
  logic [31:0] redirect_pc, out_inst, out_pc;

  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .IM_WORDS (64),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_inst        (im_inst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  // Instruction memory image; out-of-range words return junk so NOP substitution is visible.
  function automatic logic [31:0] im_word(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    case (idx)
      30'd0:   return 32'h0010_0093;
      30'd1:   return 32'h0060_0113;
      30'd37:  return 32'h0080_00EF;
      30'd38:  return 32'hDEAD_BEEF;
      default: return (idx < 30'd64) ? (32'hA500_0000 | {2'b00, idx}) : (32'hBAD0_0000 ^ addr);
    endcase
  endfunction

  always_comb im_inst = im_word(im_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] inst);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a head is consumed at the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got pc=%h inst=%h, expected no delivery", out_pc, out_inst);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream", {out_pc, out_inst}, {mon_e.pc, mon_e.inst});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    check("rst_valid", 64'(out_valid),   64'd0);
    check("rst_pc",    64'(out_pc),      64'd0);
    check("rst_inst",  64'(out_inst),    64'd0);
    check("rst_addr",  64'(im_addr),     64'd0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    tick();
    tick();

    // Reset release, streaming
    rst_n = 1'b1;
    expect_out(32'h0, 32'h0010_0093);
    expect_out(32'h4, 32'h0060_0113);
    tick();
    check("a_valid", 64'(out_valid), 64'd1);
    check("a_pc0",   64'(out_pc),    64'h0);
    tick();
    check("a_pc4",   64'(out_pc),    64'h4);
    tick();
    out_ready = 1'b0;
    check("a_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_addr",  64'(im_addr),   64'd0);
    tick();
    tick();

    // Backpressure from reset
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_head", {out_pc, out_inst}, {32'h0, 32'h0010_0093});
    end
    check("bp_addr",  64'(im_addr),   64'h8);
    check("bp_valid", 64'(out_valid), 64'd1);
    expect_out(32'h0,  32'h0010_0093);
    expect_out(32'h4,  32'h0060_0113);
    expect_out(32'h8,  32'hA500_0002);
    expect_out(32'h94, 32'h0080_00EF);
    expect_out(32'h98, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    // Redirect while full, unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h96;
    #1;
    check("redir_valid", 64'(out_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    check("redir_addr",  64'(im_addr),   64'h94);
    check("redir_empty", 64'(out_valid), 64'd0);
    tick();
    check("redir_head", {out_pc, out_inst}, {32'h94, 32'h0080_00EF});
    tick();

    // Halt for three cycles
    expect_out(32'h9C, 32'hA500_0027);
    expect_out(32'hA0, 32'hA500_0028);
    halt = 1'b1;
    check("halt_addr", 64'(im_addr), 64'h9C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_addr", 64'(im_addr), 64'h9C);
    end
    halt = 1'b0;
    tick();
    check("halt_resume", 64'(out_pc), 64'h9C);
    tick();
    tick();

    // Simultaneous halt and redirect
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0C;
    #1;
    check("hr_valid", 64'(out_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    check("hr_addr",  64'(im_addr),   64'h0C);
    check("hr_empty", 64'(out_valid), 64'd0);
    tick();
    check("hr_nopush", 64'(out_valid), 64'd0);
    check("hr_hold",   64'(im_addr),   64'h0C);
    halt = 1'b0;
    expect_out(32'h0C, 32'hA500_0003);
    tick();
    tick();

    // Fault region and sticky flag
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    expect_out(32'h100, 32'h0000_0013);
    expect_out(32'h104, 32'h0000_0013);
    tick();
    redirect_valid = 1'b0;
    check("flt_before", 64'(fetch_fault), 64'd0);
    tick();
    check("flt_set",  64'(fetch_fault), 64'd1);
    check("flt_inst", 64'(out_inst),    64'h13);
    tick();
    tick();
    check("flt_sticky", 64'(fetch_fault), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    expect_out(32'h0, 32'h0010_0093);
    tick();
    redirect_valid = 1'b0;
    check("flt_clear", 64'(fetch_fault), 64'd0);
    check("flt_addr",  64'(im_addr),     64'h0);
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch initiator for the rv32i core. It owns the PC and drives the word address into the combinational instruction memory `im`. It captures each returned instruction together with its PC into a small FIFO, which feeds the decode stage over a valid/ready handshake. Redirects from branch/jump resolution flush the FIFO and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, instruction FIFO entries (power of two, >=2).
IM_WORDS, 64, number of valid 32-bit words in `im`; fetches at or beyond this index fault.
NOP_INST, 32'h0000_0013, instruction substituted on a faulted fetch (ADDI x0,x0,0).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  reset, asynchronous assert, active-low.
im_addr  out  32  byte address to `im`; always equals the current PC (combinational from the PC register).
im_inst  in  32  instruction returned by `im` in the same cycle.
halt  in  1  when high, no new fetch is pushed; the PC holds.
redirect_valid  in  1  flush-and-jump request.
redirect_pc  in  32  jump target byte address.
out_valid  out  1  FIFO head is valid.
out_ready  in  1  decode accepts the head.
out_inst  out  32  head instruction.
out_pc  out  32  PC of the head instruction.
fetch_fault  out  1  sticky flag: a fetch hit index >= IM_WORDS.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO count=0, rd/wr pointers=0, fetch_fault=0. Consequently out_valid=0, out_inst=0, out_pc=0, im_addr=RESET_PC. Asserting reset mid-operation discards all entries immediately.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~halt & ~redirect_valid & (count<DEPTH | pop).
  - Push writes {pc, im_inst} at wr_ptr and sets pc<=pc+4, with 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
  - If a push and a pop occur in the same cycle while full, count stays DEPTH.
- Fault check: index = pc[31:2]. If index >= IM_WORDS, push NOP_INST instead of im_inst and set fetch_fault=1. The PC still advances.
- im_addr bits[1:0] are always 00. The PC is only ever loaded with aligned values.
- Redirect has highest priority.
  - On a redirect_valid edge: count<=0, pointers<=0, pc<={redirect_pc[31:2],2'b00}, fetch_fault<=0. No push and no pop occur that cycle.
  - out_valid is forced to 0 combinationally while redirect_valid=1, so decode never consumes a stale entry.
  - The next edge pushes from the target.
- Latency: an instruction at PC p appears on out_* one cycle after the edge that fetched it. Steady-state throughput is 1 instruction/cycle with out_ready=1.
- Halt: the PC is frozen and the FIFO still drains. Deasserting halt resumes from the frozen PC with no skipped or duplicated PCs.
- Backpressure: when out_ready=0 the FIFO fills to DEPTH, then the PC holds. The head stays stable (out_inst/out_pc unchanged) while out_valid=1 and out_ready=0.
- Count arithmetic uses $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package rv32i_pkg holds: XLEN=32, NOP_INST, RESET_PC default, and the typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}.
- One sub-module is natural: fetch_fifo, a parameterised synchronous FIFO of fetch_entry_t with flush, push, pop, full and empty.
- fetch_unit contains the PC register, the push/pop/redirect control, and the fault logic.

Test Plan:
- Reset release with out_ready=1 and the standard `im` image: first edge -> out_valid=1, out_pc=0x0, out_inst=0x00100093; next cycle -> out_pc=0x4, out_inst=0x00600113.
- Hold out_ready=0 for 5 cycles from reset -> count saturates at 2, im_addr stays 0x8, head stays {0x0, 0x00100093}. Then out_ready=1 -> PCs 0x0, 0x4, 0x8 are delivered in order with no gaps.
- redirect_valid=1 with redirect_pc=0x96 while the FIFO is full -> out_valid=0 that cycle, then out_pc=0x94/out_inst=0x008000EF, followed by 0x98/0xDEADBEEF.
- Assert halt for 3 cycles during streaming -> im_addr is constant and no PC is duplicated or skipped after release. Simultaneous halt and redirect -> the PC loads the target and no push occurs.
- Redirect to 4*IM_WORDS (0x100 with IM_WORDS=64) -> out_inst=0x00000013 and fetch_fault=1 (sticky). A later redirect to 0x0 clears fetch_fault.
- Assert rst_n=0 asynchronously mid-stream between edges -> out_valid drops immediately and im_addr=RESET_PC without waiting for a clock edge.
